// File: rtl/scan_decoder.sv
// Registered N-to-2^N decoder with one-hot, thermometer, clear and auto-scan modes.
// Commands enter through a valid/ready handshake and are taken only while idle.
module scan_decoder #(
    parameter int IN_W    = 3,
    parameter int OUT_W   = 2**IN_W,
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         mode,
    input  logic [IN_W-1:0]    inp,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               stop,
    output logic [OUT_W-1:0]   out,
    output logic               out_valid,
    output logic [IN_W-1:0]    scan_idx,
    output logic               scan_wrap
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SCAN = 1'b1;

    localparam logic [1:0] MODE_ONEHOT = 2'b00;
    localparam logic [1:0] MODE_THERM  = 2'b01;
    localparam logic [1:0] MODE_SCAN   = 2'b10;
    localparam logic [1:0] MODE_CLEAR  = 2'b11;

    localparam logic [IN_W-1:0] LAST_IDX = IN_W'(OUT_W - 1);

    function automatic logic [OUT_W-1:0] onehot_f(input logic [IN_W-1:0] idx);
        onehot_f = OUT_W'(1) << idx;
    endfunction

    // Bits [idx:0] set; idx = OUT_W-1 yields all ones.
    function automatic logic [OUT_W-1:0] therm_f(input logic [IN_W-1:0] idx);
        logic [OUT_W-1:0] r;
        r = {OUT_W{1'b0}};
        for (int i = 0; i < OUT_W; i++) begin
            r[i] = (i <= int'(idx)) ? 1'b1 : 1'b0;
        end
        therm_f = r;
    endfunction

    logic [0:0]         state_r,     state_s;
    logic [OUT_W-1:0]   out_r,       out_s;
    logic               out_valid_r, out_valid_s;
    logic [IN_W-1:0]    scan_idx_r,  scan_idx_s;
    logic               scan_wrap_r, scan_wrap_s;
    logic [DWELL_W-1:0] cnt_r,       cnt_s;
    logic [DWELL_W-1:0] dwell_r,     dwell_s;
    logic               accept_s;
    logic [IN_W-1:0]    idx_inc_s;

    // Handshake: ready purely from the state register.
    always_comb begin
        in_ready  = (state_r == IDLE) ? 1'b1 : 1'b0;
        accept_s  = in_valid & in_ready;
        idx_inc_s = scan_idx_r + IN_W'(1);
    end

    // Next-state and next-output computation.
    always_comb begin
        state_s     = state_r;
        out_s       = out_r;
        out_valid_s = out_valid_r;
        scan_idx_s  = scan_idx_r;
        scan_wrap_s = 1'b0;
        cnt_s       = cnt_r;
        dwell_s     = dwell_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    case (mode)
                        MODE_ONEHOT: begin
                            out_s       = onehot_f(inp);
                            out_valid_s = 1'b1;
                        end
                        MODE_THERM: begin
                            out_s       = therm_f(inp);
                            out_valid_s = 1'b1;
                        end
                        MODE_SCAN: begin
                            out_s       = onehot_f(inp);
                            out_valid_s = 1'b1;
                            scan_idx_s  = inp;
                            cnt_s       = dwell;
                            dwell_s     = dwell;
                            state_s     = SCAN;
                        end
                        MODE_CLEAR: begin
                            out_s       = {OUT_W{1'b0}};
                            out_valid_s = 1'b0;
                        end
                        default: begin
                            out_s       = out_r;
                            out_valid_s = out_valid_r;
                        end
                    endcase
                end else begin
                    state_s = IDLE;
                end
            end
            SCAN: begin
                // Stop outranks an advance, so a colliding wrap never pulses.
                if (stop) begin
                    out_s       = {OUT_W{1'b0}};
                    out_valid_s = 1'b0;
                    scan_idx_s  = {IN_W{1'b0}};
                    cnt_s       = {DWELL_W{1'b0}};
                    state_s     = IDLE;
                end else if (cnt_r != {DWELL_W{1'b0}}) begin
                    cnt_s = cnt_r - DWELL_W'(1);
                end else begin
                    scan_idx_s  = idx_inc_s;
                    out_s       = onehot_f(idx_inc_s);
                    cnt_s       = dwell_r;
                    scan_wrap_s = (scan_idx_r == LAST_IDX) ? 1'b1 : 1'b0;
                end
            end
            default: begin
                state_s     = IDLE;
                out_s       = {OUT_W{1'b0}};
                out_valid_s = 1'b0;
                scan_idx_s  = {IN_W{1'b0}};
                cnt_s       = {DWELL_W{1'b0}};
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            out_r       <= {OUT_W{1'b0}};
            out_valid_r <= 1'b0;
            scan_idx_r  <= {IN_W{1'b0}};
            scan_wrap_r <= 1'b0;
            cnt_r       <= {DWELL_W{1'b0}};
            dwell_r     <= {DWELL_W{1'b0}};
        end else begin
            state_r     <= state_s;
            out_r       <= out_s;
            out_valid_r <= out_valid_s;
            scan_idx_r  <= scan_idx_s;
            scan_wrap_r <= scan_wrap_s;
            cnt_r       <= cnt_s;
            dwell_r     <= dwell_s;
        end
    end

    assign out       = out_r;
    assign out_valid = out_valid_r;
    assign scan_idx  = scan_idx_r;
    assign scan_wrap = scan_wrap_r;

    scan_decoder_chk #(
        .OUT_W (OUT_W)
    ) u_chk (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_ready  (in_ready),
        .out       (out_r),
        .out_valid (out_valid_r),
        .scan_wrap (scan_wrap_r)
    );

endmodule

// Structural invariants of the decoder outputs.
module scan_decoder_chk #(
    parameter int OUT_W = 8
) (
    input logic             clk,
    input logic             rst_n,
    input logic             in_ready,
    input logic [OUT_W-1:0] out,
    input logic             out_valid,
    input logic             scan_wrap
);

    a_wrap_shows_zero: assert property (@(posedge clk) disable iff (!rst_n)
        scan_wrap |-> (out == OUT_W'(1)));

    a_scan_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        !in_ready |-> ($onehot(out) && out_valid));

    a_invalid_is_zero: assert property (@(posedge clk) disable iff (!rst_n)
        !out_valid |-> (out == {OUT_W{1'b0}}));

endmodule

// File: tb/tb_scan_decoder.sv
// Self-checking bench for scan_decoder: directed test-plan scenarios plus randomized
// command/scan traffic compared against an arithmetic reference model.
module tb_scan_decoder;

    logic        clk;
    logic        rst_n;
    logic        in_valid, stop;
    logic [1:0]  mode;
    logic [2:0]  inp;
    logic [7:0]  dwell;
    logic        in_ready, out_valid, scan_wrap;
    logic [7:0]  out;
    logic [2:0]  scan_idx;

    logic        in_valid_b, stop_b;
    logic [1:0]  mode_b;
    logic [3:0]  inp_b;
    logic [7:0]  dwell_b;
    logic        in_ready_b, out_valid_b, scan_wrap_b;
    logic [15:0] out_b;
    logic [3:0]  scan_idx_b;

    int n_checks = 0;
    int n_errors = 0;

    scan_decoder dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .mode(mode), .inp(inp), .dwell(dwell), .stop(stop), .out(out),
        .out_valid(out_valid), .scan_idx(scan_idx), .scan_wrap(scan_wrap)
    );

    scan_decoder #(.IN_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .mode(mode_b), .inp(inp_b), .dwell(dwell_b), .stop(stop_b), .out(out_b),
        .out_valid(out_valid_b), .scan_idx(scan_idx_b), .scan_wrap(scan_wrap_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: plain arithmetic over the decoder's rules.
    function automatic int ref_onehot(int idx);
        return 2**idx;
    endfunction

    function automatic int ref_therm(int idx);
        return 2**(idx + 1) - 1;
    endfunction

    function automatic int ref_idx(int start, int d, int t, int n);
        return (start + t / (d + 1)) % n;
    endfunction

    function automatic int ref_wrap(int start, int d, int t, int n);
        return (t > 0 && (t % (d + 1)) == 0 && ref_idx(start, d, t, n) == 0) ? 1 : 0;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cyc();
        n_checks++;
        if (out !== 8'h00 || out_valid !== 1'b0 || scan_idx !== 3'd0 ||
            scan_wrap !== 1'b0 || in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL reset: out=%h vld=%b idx=%0d wrap=%b rdy=%b, want 00/0/0/0/1",
                     out, out_valid, scan_idx, scan_wrap, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_onehot_sweep();
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; mode = 2'b00; inp = 3'(i);
            cyc();
            n_checks++;
            if (out !== 8'(ref_onehot(i)) || out_valid !== 1'b1) begin
                n_errors++;
                $display("FAIL onehot[%0d]: got %h/%b want %h/1", i, out, out_valid, 8'(ref_onehot(i)));
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_thermometer();
        int vals[3] = '{0, 3, 7};
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; mode = 2'b01; inp = 3'(vals[k]);
            cyc();
            n_checks++;
            if (out !== 8'(ref_therm(vals[k])) || out_valid !== 1'b1) begin
                n_errors++;
                $display("FAIL therm[%0d]: got %h/%b want %h/1", vals[k], out, out_valid, 8'(ref_therm(vals[k])));
            end
        end
        mode = 2'b11;
        cyc();
        in_valid = 1'b0;
        n_checks++;
        if (out !== 8'h00 || out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL clear: got %h/%b want 00/0", out, out_valid);
        end
    endtask

    task automatic test_idle_boundaries();
        in_valid = 1'b1; mode = 2'b00; inp = 3'd3;
        cyc();
        in_valid = 1'b0; stop = 1'b1;
        cyc();
        n_checks++;
        if (out !== 8'h08 || out_valid !== 1'b1 || in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL stop_idle: got %h/%b rdy=%b want 08/1/1", out, out_valid, in_ready);
        end
        in_valid = 1'b1; mode = 2'b01; inp = 3'd2;
        cyc();
        in_valid = 1'b0; stop = 1'b0;
        n_checks++;
        if (out !== 8'h07 || out_valid !== 1'b1 || in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL valid_with_stop: got %h/%b rdy=%b want 07/1/1", out, out_valid, in_ready);
        end
    endtask

    task automatic test_scan();
        int e;
        in_valid = 1'b1; mode = 2'b10; inp = 3'd6; dwell = 8'd2;
        cyc();
        // Keep offering a conflicting command; it must be ignored.
        mode = 2'b00; inp = 3'd0;
        for (int t = 0; t < 9; t++) begin
            e = ref_idx(6, 2, t, 8);
            n_checks++;
            if (out !== 8'(ref_onehot(e)) || scan_idx !== 3'(e) ||
                scan_wrap !== 1'(ref_wrap(6, 2, t, 8)) || in_ready !== 1'b0 || out_valid !== 1'b1) begin
                n_errors++;
                $display("FAIL scan t=%0d: out=%h idx=%0d wrap=%b rdy=%b want %h/%0d/%0d/0",
                         t, out, scan_idx, scan_wrap, in_ready, 8'(ref_onehot(e)), e, ref_wrap(6, 2, t, 8));
            end
            cyc();
        end
        in_valid = 1'b0; stop = 1'b1;
        cyc();
        stop = 1'b0;
        n_checks++;
        if (out !== 8'h00 || out_valid !== 1'b0 || scan_idx !== 3'd0 || in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL scan_stop: out=%h vld=%b idx=%0d rdy=%b want 00/0/0/1", out, out_valid, scan_idx, in_ready);
        end
    endtask

    task automatic test_stop_collision();
        in_valid = 1'b1; mode = 2'b10; inp = 3'd6; dwell = 8'd0;
        cyc();
        in_valid = 1'b0;
        cyc();
        n_checks++;
        if (out !== 8'h80 || scan_idx !== 3'd7) begin
            n_errors++;
            $display("FAIL collide_pre: out=%h idx=%0d want 80/7", out, scan_idx);
        end
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        n_checks++;
        if (out !== 8'h00 || scan_wrap !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL collide: out=%h wrap=%b rdy=%b vld=%b want 00/0/1/0", out, scan_wrap, in_ready, out_valid);
        end
        cyc();
        n_checks++;
        if (out !== 8'h00 || scan_wrap !== 1'b0) begin
            n_errors++;
            $display("FAIL collide_after: out=%h wrap=%b want 00/0", out, scan_wrap);
        end
    endtask

    task automatic test_async_reset();
        in_valid = 1'b1; mode = 2'b10; inp = 3'd2; dwell = 8'd1;
        cyc();
        in_valid = 1'b0;
        cyc();
        cyc();
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out !== 8'h00 || out_valid !== 1'b0 || scan_idx !== 3'd0 ||
            scan_wrap !== 1'b0 || in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL async_reset: out=%h vld=%b idx=%0d wrap=%b rdy=%b want 00/0/0/0/1",
                     out, out_valid, scan_idx, scan_wrap, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b1; mode = 2'b00; inp = 3'd5;
        cyc();
        in_valid = 1'b0;
        n_checks++;
        if (out !== 8'h20 || out_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL post_reset: got %h/%b want 20/1", out, out_valid);
        end
    endtask

    task automatic test_param_w4();
        in_valid_b = 1'b1; mode_b = 2'b10; inp_b = 4'd15; dwell_b = 8'd0;
        cyc();
        in_valid_b = 1'b0;
        n_checks++;
        if (out_b !== 16'(ref_onehot(15)) || scan_wrap_b !== 1'b0) begin
            n_errors++;
            $display("FAIL w4_scan0: out=%h wrap=%b want 8000/0", out_b, scan_wrap_b);
        end
        cyc();
        n_checks++;
        if (out_b !== 16'(ref_onehot(0)) || scan_wrap_b !== 1'b1 || scan_idx_b !== 4'd0) begin
            n_errors++;
            $display("FAIL w4_wrap: out=%h wrap=%b idx=%0d want 0001/1/0", out_b, scan_wrap_b, scan_idx_b);
        end
        stop_b = 1'b1;
        cyc();
        stop_b = 1'b0;
        in_valid_b = 1'b1; mode_b = 2'b01; inp_b = 4'd15;
        cyc();
        in_valid_b = 1'b0;
        n_checks++;
        if (out_b !== 16'(ref_therm(15)) || out_valid_b !== 1'b1) begin
            n_errors++;
            $display("FAIL w4_therm: out=%h vld=%b want ffff/1", out_b, out_valid_b);
        end
    endtask

    task automatic test_random();
        int exp_out = 0;
        int exp_vld = 0;
        int m, i, d, len, e;
        for (int it = 0; it < 60; it++) begin
            m = int'($urandom_range(0, 3));
            i = int'($urandom_range(0, 7));
            if (m != 2) begin
                in_valid = 1'b1; mode = 2'(m); inp = 3'(i); stop = 1'($urandom_range(0, 1));
                cyc();
                in_valid = 1'b0;
                exp_out = (m == 0) ? ref_onehot(i) : (m == 1) ? ref_therm(i) : 0;
                exp_vld = (m == 3) ? 0 : 1;
                n_checks++;
                if (out !== 8'(exp_out) || out_valid !== 1'(exp_vld) || in_ready !== 1'b1) begin
                    n_errors++;
                    $display("FAIL rand_cmd m=%0d i=%0d: got %h/%b rdy=%b want %h/%0d/1",
                             m, i, out, out_valid, in_ready, 8'(exp_out), exp_vld);
                end
                stop = 1'($urandom_range(0, 1));
                cyc();
                stop = 1'b0;
                n_checks++;
                if (out !== 8'(exp_out) || out_valid !== 1'(exp_vld)) begin
                    n_errors++;
                    $display("FAIL rand_hold: got %h/%b want %h/%0d", out, out_valid, 8'(exp_out), exp_vld);
                end
            end else begin
                d = int'($urandom_range(0, 3));
                len = int'($urandom_range(1, 20));
                in_valid = 1'b1; mode = 2'b10; inp = 3'(i); dwell = 8'(d);
                cyc();
                for (int t = 0; t < len; t++) begin
                    e = ref_idx(i, d, t, 8);
                    n_checks++;
                    if (out !== 8'(ref_onehot(e)) || scan_idx !== 3'(e) ||
                        scan_wrap !== 1'(ref_wrap(i, d, t, 8)) || in_ready !== 1'b0) begin
                        n_errors++;
                        $display("FAIL rand_scan s=%0d d=%0d t=%0d: out=%h idx=%0d wrap=%b rdy=%b want %h/%0d/%0d/0",
                                 i, d, t, out, scan_idx, scan_wrap, in_ready,
                                 8'(ref_onehot(e)), e, ref_wrap(i, d, t, 8));
                    end
                    in_valid = 1'($urandom_range(0, 1));
                    mode = 2'($urandom_range(0, 3));
                    inp = 3'($urandom_range(0, 7));
                    dwell = 8'($urandom_range(0, 255));
                    cyc();
                end
                in_valid = 1'b0; stop = 1'b1;
                cyc();
                stop = 1'b0;
                exp_out = 0;
                exp_vld = 0;
                n_checks++;
                if (out !== 8'h00 || out_valid !== 1'b0 || scan_idx !== 3'd0 ||
                    in_ready !== 1'b1 || scan_wrap !== 1'b0) begin
                    n_errors++;
                    $display("FAIL rand_stop: out=%h vld=%b idx=%0d rdy=%b wrap=%b want 00/0/0/1/0",
                             out, out_valid, scan_idx, in_ready, scan_wrap);
                end
            end
        end
    endtask

    initial begin
        in_valid = 1'b0; stop = 1'b0; mode = 2'b00; inp = 3'd0; dwell = 8'd0;
        in_valid_b = 1'b0; stop_b = 1'b0; mode_b = 2'b00; inp_b = 4'd0; dwell_b = 8'd0;
        test_reset();
        test_onehot_sweep();
        test_thermometer();
        test_idle_boundaries();
        test_scan();
        test_stop_collision();
        test_async_reset();
        test_param_w4();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
